// File: rtl/mem_sram_arb_pkg.sv
// Shared constants, request/response records and address helpers for the
// mem_sram bank arbiter.
package mem_sram_arb_pkg;

   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 256;
   localparam int LINE_LSB = 5;
   localparam int LINE_MSB = 14;
   localparam int BANK_LSB = 15;
   localparam int BANK_MSB = 18;
   localparam int BANK_W   = BANK_MSB - BANK_LSB + 1;
   localparam int LINE_W   = LINE_MSB - LINE_LSB + 1;
   localparam int IDX_W    = 3;   // wide enough for up to 8 requesters

   typedef struct packed {
      logic              write;
      logic              mask_en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] mask;
   } mem_req_t;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
      logic             err;
      logic             is_read;
   } rsp_tag_t;

   function automatic logic bank_match(input logic [ADDR_W-1:0] addr,
                                       input logic [BANK_W-1:0] bank_id);
      return addr[BANK_MSB:BANK_LSB] == bank_id;
   endfunction

   function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
      return addr[LINE_MSB:LINE_LSB];
   endfunction

endpackage

// File: rtl/mem_sram_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (wrapping); the pointer moves past the winner on every grant.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int PTR_W = $clog2(N);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] lo_idx, hi_idx;
   logic             lo_hit, hi_hit;

   // lo_* is the lowest requester overall, hi_* the lowest at or after ptr_q.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      lo_hit = 1'b0;
      hi_hit = 1'b0;
      lo_idx = '0;
      hi_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_hit = 1'b1;
            lo_idx = PTR_W'(i);
            if (PTR_W'(i) >= ptr_q) begin
               hi_hit = 1'b1;
               hi_idx = PTR_W'(i);
            end
         end
      end
   end

   always_comb begin
      grant     = '0;
      grant_idx = hi_hit ? hi_idx : lo_idx;
      ptr_d     = ptr_q;
      if (enable && lo_hit) begin
         grant[grant_idx] = 1'b1;
         ptr_d = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mem_sram_arb.sv
// Shares one single-port mem_sram bank between N_REQ requesters: round-robin
// accept, registered bank issue, and a fixed two-cycle response pulse.
module mem_sram_arb
   import mem_sram_arb_pkg::*;
#(
   parameter int             N_REQ   = 4,
   parameter logic [BANK_W-1:0] BANK_ID = 4'd0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_enable,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ-1:0]          req_write,
   input  logic [N_REQ-1:0]          req_mask_en,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   input  logic [N_REQ*DATA_W-1:0]   req_mask,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [N_REQ-1:0]          rsp_err,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      mem_cs,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic                      mem_mask_enable,
   output logic [BANK_W-1:0]         mem_id,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_data_in,
   output logic [DATA_W-1:0]         mem_mask,
   input  logic [DATA_W-1:0]         mem_data_out
);

   localparam int PTR_W = $clog2(N_REQ);

   logic [N_REQ-1:0]  grant;
   logic [PTR_W-1:0]  grant_idx;
   logic              accept;
   logic              sel_match;
   mem_req_t          sel_req;

   logic              cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, men_q, men_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d, mask_q, mask_d;
   rsp_tag_t          s1_q, s1_d, s2_q;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .enable    (cfg_enable & ~rst),
      .req       (req_valid),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign accept    = |grant;

   always_comb begin
      sel_req = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_req.write   = req_write[i];
            sel_req.mask_en = req_mask_en[i];
            sel_req.addr    = req_addr[i*ADDR_W +: ADDR_W];
            sel_req.wdata   = req_wdata[i*DATA_W +: DATA_W];
            sel_req.mask    = req_mask[i*DATA_W +: DATA_W];
         end
      end
   end

   assign sel_match = bank_match(sel_req.addr, BANK_ID);

   // A wrong-bank request never reaches the bank; only its error tag travels on.
   always_comb begin
      cs_d   = accept & sel_match;
      rd_d   = cs_d & ~sel_req.write;
      wr_d   = cs_d & sel_req.write;
      men_d  = wr_d & sel_req.mask_en;
      addr_d = addr_q;
      data_d = data_q;
      mask_d = mask_q;
      if (accept) begin
         addr_d = sel_req.addr;
         data_d = sel_req.wdata;
         mask_d = sel_req.mask;
      end
      s1_d.valid   = accept;
      s1_d.idx     = IDX_W'(grant_idx);
      s1_d.err     = accept & ~sel_match;
      s1_d.is_read = accept & ~sel_req.write;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the wide data registers are reset as well because they drive bank pins that must read 0 out of reset.
         cs_q   <= 1'b0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         men_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         mask_q <= '0;
         s1_q   <= '0;
         s2_q   <= '0;
      end else begin
         cs_q   <= cs_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         men_q  <= men_d;
         addr_q <= addr_d;
         data_q <= data_d;
         mask_q <= mask_d;
         s1_q   <= s1_d;
         s2_q   <= s1_q;
      end
   end

   assign mem_cs          = cs_q;
   assign mem_read        = rd_q;
   assign mem_write       = wr_q;
   assign mem_mask_enable = men_q;
   assign mem_addr        = addr_q;
   assign mem_id          = addr_q[BANK_MSB:BANK_LSB];
   assign mem_data_in     = data_q;
   assign mem_mask        = mask_q;

   always_comb begin
      rsp_valid = '0;
      rsp_err   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (s2_q.valid && (s2_q.idx == IDX_W'(i))) begin
            rsp_valid[i] = 1'b1;
            rsp_err[i]   = s2_q.err;
         end
      end
   end

   // Bank read data is forced to 0 except on a good read response.
   assign rsp_rdata = (s2_q.valid && s2_q.is_read && !s2_q.err) ? mem_data_out : '0;

endmodule
